// File: rtl/mem_responder_if.sv
// Request/response bus between the core's memory initiator and mem_responder.
`timescale 1ns/1ps
interface mem_responder_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic [3:0]            req_wstrb;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [31:0]           resp_rdata;
  logic                  resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed RAM target with a fixed request-to-response latency and
// byte-lane writes; one outstanding transaction at a time.
`timescale 1ns/1ps
module mem_responder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus
);

  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam int AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;
  localparam logic [IDX_W:0]   DEPTH_LIM = (IDX_W + 1)'(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_count, w_count_nxt;
  logic              w_commit;
  logic              w_accept;

  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [3:0]            r_wstrb;
  logic [31:0]           r_rdata;
  logic                  r_err;
  logic [31:0]           r_mem [DEPTH_WORDS];

  logic                  w_c_we;
  logic [ADDR_WIDTH-1:0] w_c_addr;
  logic [31:0]           w_c_wdata;
  logic [3:0]            w_c_wstrb;
  logic [IDX_W-1:0]      w_c_idx;
  logic                  w_c_err;
  logic                  w_mem_we;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++)
      if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
    return res;
  endfunction

  assign bus.req_ready  = (r_state == IDLE) && !reset;
  assign bus.resp_valid = (r_state == RESP);
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;
  assign w_accept       = bus.req_valid && bus.req_ready;

  // With LATENCY==1 the commit edge is the accept edge, so the live inputs feed it.
  assign w_c_we    = (r_state == IDLE) ? bus.req_we    : r_we;
  assign w_c_addr  = (r_state == IDLE) ? bus.req_addr  : r_addr;
  assign w_c_wdata = (r_state == IDLE) ? bus.req_wdata : r_wdata;
  assign w_c_wstrb = (r_state == IDLE) ? bus.req_wstrb : r_wstrb;
  assign w_c_idx   = w_c_addr[ADDR_WIDTH-1:2];
  assign w_c_err   = (w_c_addr[1:0] != 2'b00) || ({1'b0, w_c_idx} >= DEPTH_LIM);
  assign w_mem_we  = w_commit && !reset && w_c_we && !w_c_err;

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_commit    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (LATENCY == 1) begin
            w_state_nxt = RESP;
            w_commit    = 1'b1;
          end else begin
            w_state_nxt = BUSY;
            w_count_nxt = CNT_INIT;
          end
        end
      end
      BUSY: begin
        if (r_count == '0) begin
          w_state_nxt = RESP;
          w_commit    = 1'b1;
        end else begin
          w_count_nxt = r_count - 1'b1;
        end
      end
      RESP: begin
        if (bus.resp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_count <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      if (w_commit) begin
        r_err <= w_c_err;
        if (w_c_err || w_c_we) r_rdata <= '0;
        else                   r_rdata <= r_mem[w_c_idx[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we    <= bus.req_we;
      r_addr  <= bus.req_addr;
      r_wdata <= bus.req_wdata;
      r_wstrb <= bus.req_wstrb;
    end
    if (w_mem_we)
      r_mem[w_c_idx[AW-1:0]] <= merge_lanes(r_mem[w_c_idx[AW-1:0]], w_c_wdata, w_c_wstrb);
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three builds (LATENCY 2, 1, 4) driven against a
// word-array reference model of the memory.
`timescale 1ns/1ps
module tb_mem_responder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        req_valid  [3];
  logic        req_we     [3];
  logic [31:0] req_addr   [3];
  logic [31:0] req_wdata  [3];
  logic [3:0]  req_wstrb  [3];
  logic        resp_ready [3];
  logic        req_ready  [3];
  logic        resp_valid [3];
  logic [31:0] resp_rdata [3];
  logic        resp_err   [3];

  logic [31:0] mdl [3][1024];
  int n_pass = 0;
  int n_chk  = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    mem_responder_if #(.ADDR_WIDTH(32)) bus ();
    assign bus.req_valid  = req_valid[g];
    assign bus.req_we     = req_we[g];
    assign bus.req_addr   = req_addr[g];
    assign bus.req_wdata  = req_wdata[g];
    assign bus.req_wstrb  = req_wstrb[g];
    assign bus.resp_ready = resp_ready[g];
    assign req_ready[g]   = bus.req_ready;
    assign resp_valid[g]  = bus.resp_valid;
    assign resp_rdata[g]  = bus.resp_rdata;
    assign resp_err[g]    = bus.resp_err;
    mem_responder #(.ADDR_WIDTH(32), .DEPTH_WORDS(1024), .LATENCY(L)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
    );
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 1 : 4);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  // Caller is at a negedge; returns at the negedge after the response handshake.
  task automatic do_txn(input int d, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        input int hold, input bit early,
                        output logic [31:0] rd, output logic er);
    int n;
    n = 0;
    while (!req_ready[d] && n < 40) begin @(negedge clk); n++; end
    if (n >= 40) chk("accept_timeout", 32'd1, 32'd0);
    req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr;
    req_wdata[d] = wdata; req_wstrb[d] = strb;
    @(negedge clk);
    req_valid[d] = 1'b0; req_we[d] = 1'($urandom); req_addr[d] = $urandom;
    req_wdata[d] = $urandom; req_wstrb[d] = 4'($urandom);
    n = 1;
    while (!resp_valid[d] && n < 40) begin
      resp_ready[d] = early & 1'($urandom);
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'(lat_of(d)));
    resp_ready[d] = 1'b0;
    rd = resp_rdata[d];
    er = resp_err[d];
    chk("req_ready_in_resp", 32'(req_ready[d]), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(resp_valid[d]), 32'd1);
      chk("hold_rdata", resp_rdata[d], rd);
      chk("hold_err",   32'(resp_err[d]), 32'(er));
      chk("hold_ready", 32'(req_ready[d]), 32'd0);
    end
    resp_ready[d] = 1'b1;
    @(negedge clk);
    resp_ready[d] = 1'b0;
    chk("valid_drop", 32'(resp_valid[d]), 32'd0);
  endtask

  task automatic txn(input int d, input bit we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] strb,
                     input int hold, input bit early, input string tag,
                     output logic [31:0] rd);
    logic [31:0] exp_rd;
    logic        exp_er;
    logic        er;
    int          idx;
    exp_er = (addr[1:0] != 2'b00) || (addr[31:2] >= 30'd1024);
    idx    = int'(addr[11:2]);
    exp_rd = '0;
    if (!exp_er && !we) exp_rd = mdl[d][idx];
    if (!exp_er && we)
      for (int b = 0; b < 4; b++)
        if (strb[b]) mdl[d][idx][8*b +: 8] = wdata[8*b +: 8];
    do_txn(d, we, addr, wdata, strb, hold, early, rd, er);
    chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_err"}, 32'(er), 32'(exp_er));
  endtask

  // Raise reset k negedges after the accept negedge; the write must vanish.
  task automatic abort_write(input int d, input logic [31:0] addr,
                             input logic [31:0] wdata, input int k);
    int seen;
    seen = 0;
    while (!req_ready[d]) @(negedge clk);
    req_valid[d] = 1'b1; req_we[d] = 1'b1; req_addr[d] = addr;
    req_wdata[d] = wdata; req_wstrb[d] = 4'hF;
    for (int j = 1; j <= k; j++) begin
      @(negedge clk);
      req_valid[d] = 1'b0;
      if (resp_valid[d]) seen++;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_rst_valid", 32'(resp_valid[d]), 32'd0);
    chk("abort_rst_rdata", resp_rdata[d], 32'd0);
    chk("abort_rst_err",   32'(resp_err[d]), 32'd0);
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (resp_valid[d]) seen++;
    end
    chk("abort_no_resp", 32'(seen), 32'd0);
  endtask

  logic [31:0] rd;
  logic [31:0] a;

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
      req_wdata[d] = '0; req_wstrb[d] = '0; resp_ready[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("rst_req_ready",  32'(req_ready[d]), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid[d]), 32'd0);
      chk("rst_resp_rdata", resp_rdata[d], 32'd0);
      chk("rst_resp_err",   32'(resp_err[d]), 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);

    for (int d = 0; d < 3; d++)
      for (int w = 0; w < 16; w++)
        txn(d, 1'b1, 32'(w * 4), $urandom, 4'hF, 0, 1'b0, "init", rd);

    // Full write then read back
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, "t1_wr", rd);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, "t1_rd", rd);
    chk("t1_value", rd, 32'hDEADBEEF);

    // Partial byte-lane write
    txn(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 0, 1'b0, "t2_pre", rd);
    txn(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 0, 1'b0, "t2_wr", rd);
    txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, "t2_rd", rd);
    chk("t2_value", rd, 32'h11BB33DD);
    txn(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 0, 1'b0, "t2_nostrb", rd);
    txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, "t2_rd2", rd);

    // Misaligned and out-of-range requests
    txn(0, 1'b0, 32'h22,   32'h0, 4'h0, 0, 1'b0, "t3_rd_mis", rd);
    txn(0, 1'b0, 32'h1000, 32'h0, 4'h0, 0, 1'b0, "t3_rd_oor", rd);
    txn(0, 1'b1, 32'h22,   32'h55555555, 4'hF, 0, 1'b0, "t3_wr_mis", rd);
    txn(0, 1'b1, 32'h1000, 32'h66666666, 4'hF, 0, 1'b0, "t3_wr_oor", rd);
    txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, "t3_rd20", rd);
    txn(0, 1'b0, 32'h0,  32'h0, 4'h0, 0, 1'b0, "t3_rd0", rd);

    // Backpressure on the response
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 5, 1'b0, "t4_hold", rd);

    // Reset before / on the commit edge discards the write
    txn(2, 1'b1, 32'h30, 32'h01020304, 4'hF, 0, 1'b0, "t5_pre2", rd);
    txn(0, 1'b1, 32'h30, 32'h0A0B0C0D, 4'hF, 0, 1'b0, "t5_pre0", rd);
    abort_write(2, 32'h30, 32'hCAFEF00D, 2);
    txn(2, 1'b0, 32'h30, 32'h0, 4'h0, 0, 1'b0, "t5_rd_a", rd);
    abort_write(2, 32'h30, 32'hCAFEF00D, 3);
    txn(2, 1'b0, 32'h30, 32'h0, 4'h0, 0, 1'b0, "t5_rd_b", rd);
    abort_write(0, 32'h30, 32'hCAFEF00D, 1);
    txn(0, 1'b0, 32'h30, 32'h0, 4'h0, 0, 1'b0, "t5_rd_c", rd);

    // Random traffic on every build
    for (int d = 0; d < 3; d++) begin
      for (int t = 0; t < 60; t++) begin
        case ($urandom_range(0, 9))
          0:       a = 32'($urandom_range(0, 63));
          1:       a = 32'h1000 | ($urandom & 32'hFFFF_FFFC);
          default: a = 32'($urandom_range(0, 15) * 4);
        endcase
        txn(d, 1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 2),
            1'($urandom), "rand", rd);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
